// File: rtl/intf_arb_pkg.sv
// Shared types and helpers for the round-robin interface arbiter.
package intf_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // Index width for n requesters; never narrower than one bit.
  function automatic int src_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/intf_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of vec at or after ptr, wrapping.
module rr_pick
  import intf_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         vec,
  input  logic [src_w(NREQ)-1:0]  ptr,
  output logic [src_w(NREQ)-1:0]  idx,
  output logic                    found
);

  localparam int SW = src_w(NREQ);

  logic [NREQ-1:0] rot;
  int              sel;

  // Rotate so ptr lands at bit 0, priority-encode, then map back.
  always_comb begin
    rot   = '0;
    found = 1'b0;
    sel   = 0;
    for (int i = 0; i < NREQ; i++) begin
      rot[i] = vec[SW'((i + int'(ptr)) % NREQ)];
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        sel   = i;
      end
    end
    idx = SW'((sel + int'(ptr)) % NREQ);
  end

endmodule

// File: rtl/intf_rr_arbiter.sv
// Round-robin arbiter sharing one registered interface output stage between
// NREQ requesters, with the grant locked for a burst (bounded by MAX_BURST).
module intf_rr_arbiter
  import intf_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  input  logic [NREQ-1:0]         req_last,
  output logic [NREQ-1:0]         req_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [src_w(NREQ)-1:0]  out_src,
  input  logic                    out_ready,
  output logic                    busy
);

  localparam int SW = src_w(NREQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_e        state_q, state_d;
  logic [SW-1:0]     grant_q, grant_d;
  logic [SW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]     beat_cnt_q, beat_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [SW-1:0]     out_src_q, out_src_d;

  logic [WIDTH-1:0]  beat [NREQ];
  logic [SW-1:0]     pick_idx;
  logic              pick_found;
  logic              slot_free;
  logic              accept;
  logic              burst_end;
  logic [SW-1:0]     ptr_after_grant;

  for (genvar g = 0; g < NREQ; g++) begin : g_beat
    assign beat[g] = req_data[g*WIDTH +: WIDTH];
  end

  rr_pick #(.NREQ(NREQ)) u_pick (
    .vec   (req_valid),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Ready depends only on registered state and out_ready, never on req_valid.
  assign slot_free = !out_valid_q || out_ready;
  assign accept    = (state_q == ARB_GRANT) && slot_free && req_valid[grant_q];
  assign burst_end = req_last[grant_q] || (beat_cnt_q == CW'(MAX_BURST - 1));
  assign ptr_after_grant = (grant_q == SW'(NREQ - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    req_ready = '0;
    if (state_q == ARB_GRANT && slot_free) begin
      req_ready[grant_q] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = beat[grant_q];
      out_src_d   = grant_q;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (accept) begin
          if (burst_end) begin
            rr_ptr_d   = ptr_after_grant;
            beat_cnt_d = '0;
            state_d    = ARB_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign busy      = (state_q == ARB_GRANT);

endmodule

// File: tb/tb_intf_rr_arbiter.sv
// Bench for intf_rr_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_intf_rr_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int MAXB = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    valid;
  logic [3:0]    last;
  logic [7:0]    dat [4];
  logic [31:0]   req_data;
  logic [3:0]    req_ready;
  logic          out_valid;
  logic [7:0]    out_data;
  logic [1:0]    out_src;
  logic          ordy;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: who holds the grant, beats delivered, output slot.
  bit            m_busy;
  int            m_gnt;
  int            m_ptr;
  int            m_cnt;
  bit            m_ov;
  logic [7:0]    m_od;
  int            m_os;
  int            m_acc;

  int            srcs [$];
  int            n1;
  bit            done2;

  assign req_data = {dat[3], dat[2], dat[1], dat[0]};

  always #5 clk = ~clk;

  intf_rr_arbiter #(.NREQ(NREQ), .WIDTH(W), .MAX_BURST(MAXB)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (valid),
    .req_data  (req_data),
    .req_last  (last),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (ordy),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_gnt = 0; m_ptr = 0; m_cnt = 0;
    m_ov = 0; m_od = 8'h00; m_os = 0; m_acc = -1;
  endtask

  function automatic logic [3:0] model_ready();
    logic [3:0] r;
    r = 4'b0000;
    if (m_busy && (!m_ov || ordy)) r[m_gnt[1:0]] = 1'b1;
    return r;
  endfunction

  task automatic model_edge();
    bit acc;
    int idx;
    acc   = 0;
    m_acc = -1;
    if (m_busy) begin
      if ((!m_ov || ordy) && valid[m_gnt[1:0]]) begin
        acc   = 1;
        m_acc = m_gnt;
        m_od  = dat[m_gnt[1:0]];
        m_os  = m_gnt;
        m_cnt = m_cnt + 1;
        if (last[m_gnt[1:0]] || m_cnt == MAXB) begin
          m_busy = 0;
          m_ptr  = (m_gnt + 1) % NREQ;
          m_cnt  = 0;
        end
      end
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (valid[idx[1:0]]) begin
          m_busy = 1;
          m_gnt  = idx;
          break;
        end
      end
    end
    if (acc) m_ov = 1;
    else if (m_ov && ordy) m_ov = 0;
  endtask

  // Called just after a falling edge with inputs already set.
  task automatic step();
    #1;
    chk("req_ready", {28'd0, req_ready}, {28'd0, model_ready()});
    model_edge();
    @(posedge clk);
    @(negedge clk);
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    chk("out_data",  {24'd0, out_data},  {24'd0, m_od});
    chk("out_src",   {30'd0, out_src},   m_os);
    chk("busy",      {31'd0, busy},      {31'd0, m_busy});
  endtask

  task automatic do_async_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data",  {24'd0, out_data},  32'd0);
    chk("rst_out_src",   {30'd0, out_src},   32'd0);
    chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_inputs();
    valid = 4'b0000;
    last  = 4'b0000;
    for (int i = 0; i < 4; i++) dat[i] = 8'h00;
  endtask

  initial begin
    rst  = 1'b1;
    ordy = 1'b1;
    clear_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_data",  {24'd0, out_data},  32'd0);
    chk("reset_busy",      {31'd0, busy},      32'd0);
    chk("reset_req_ready", {28'd0, req_ready}, 32'd0);
    rst = 1'b0;

    // Requester 2: three-beat burst, then pointer must sit at 3.
    valid = 4'b0100; dat[2] = 8'h11;
    step();
    chk("t1_busy_after_pick", {31'd0, busy}, 32'd1);
    step();
    chk("t1_beat1", {24'd0, out_data}, 32'h11);
    chk("t1_src",   {30'd0, out_src},  32'd2);
    dat[2] = 8'h22;
    step();
    chk("t1_beat2", {24'd0, out_data}, 32'h22);
    dat[2] = 8'h33; last[2] = 1'b1;
    step();
    chk("t1_beat3", {24'd0, out_data}, 32'h33);
    chk("t1_released", {31'd0, busy}, 32'd0);
    valid = 4'b1001; last = 4'b1111; dat[0] = 8'hA0; dat[3] = 8'hA3;
    step();
    step();
    chk("t1_ptr_after_req2", {30'd0, out_src}, 32'd3);
    chk("t1_ptr_data", {24'd0, out_data}, 32'hA3);
    valid = 4'b0000;
    step();
    do_async_reset();

    // All four requesters with single-beat bursts.
    valid = 4'b1111; last = 4'b1111;
    for (int i = 0; i < 4; i++) dat[i] = 8'h40 + 8'(i);
    srcs.delete();
    for (int c = 0; c < 10; c++) begin
      step();
      if (m_acc >= 0) srcs.push_back(int'(out_src));
    end
    chk("t2_count", srcs.size(), 32'd5);
    if (srcs.size() == 5) begin
      chk("t2_src0", srcs[0], 32'd0);
      chk("t2_src1", srcs[1], 32'd1);
      chk("t2_src2", srcs[2], 32'd2);
      chk("t2_src3", srcs[3], 32'd3);
      chk("t2_src4", srcs[4], 32'd0);
    end
    clear_inputs();
    step();
    do_async_reset();

    // Requester 1 streams 10 unflagged beats; requester 2 waits with one beat.
    srcs.delete();
    n1 = 0; done2 = 0;
    last[2] = 1'b1; dat[2] = 8'h77;
    for (int c = 0; c < 60; c++) begin
      if (n1 == 10 && done2) break;
      dat[1]   = 8'h30 + 8'(n1);
      valid[1] = (n1 < 10);
      valid[2] = !done2;
      step();
      if (m_acc == 1) begin n1++; srcs.push_back(int'(out_src)); end
      if (m_acc == 2) begin done2 = 1; srcs.push_back(int'(out_src)); end
    end
    chk("t3_all_delivered", {31'd0, (n1 == 10 && done2)}, 32'd1);
    chk("t3_count", srcs.size(), 32'd11);
    if (srcs.size() == 11) begin
      for (int i = 0; i < 8; i++) chk("t3_first_burst", srcs[i], 32'd1);
      chk("t3_req2_next", srcs[8], 32'd2);
      chk("t3_req1_back0", srcs[9], 32'd1);
      chk("t3_req1_back1", srcs[10], 32'd1);
    end
    clear_inputs();
    do_async_reset();

    // Backpressure: out_ready low for five cycles mid-burst.
    valid[0] = 1'b1; dat[0] = 8'h50;
    step();
    step();
    dat[0] = 8'h51;
    step();
    ordy = 1'b0; dat[0] = 8'h52;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("t4_stall_ready", {28'd0, req_ready}, 32'd0);
      chk("t4_stall_data", {24'd0, out_data}, 32'h51);
    end
    ordy = 1'b1;
    step();
    chk("t4_resume_data", {24'd0, out_data}, 32'h52);
    dat[0] = 8'h53; last[0] = 1'b1;
    step();
    chk("t4_last_data", {24'd0, out_data}, 32'h53);
    clear_inputs();
    step();
    do_async_reset();

    // Reset in the middle of beat 2.
    valid[1] = 1'b1; dat[1] = 8'h61;
    step();
    step();
    dat[1] = 8'h62;
    do_async_reset();
    valid = 4'b1010; last = 4'b1111; dat[1] = 8'h71; dat[3] = 8'h73;
    step();
    step();
    chk("t5_first_after_rst", {30'd0, out_src}, 32'd1);
    chk("t5_data_after_rst", {24'd0, out_data}, 32'h71);
    clear_inputs();
    step();
    do_async_reset();

    // Same-cycle drain and accept.
    valid[0] = 1'b1; dat[0] = 8'hA5;
    step();
    step();
    chk("t6_first_valid", {31'd0, out_valid}, 32'd1);
    dat[0] = 8'h5A; last[0] = 1'b1;
    step();
    chk("t6_valid_held", {31'd0, out_valid}, 32'd1);
    chk("t6_new_data", {24'd0, out_data}, 32'h5A);
    clear_inputs();
    step();

    // Random traffic against the model, with occasional asynchronous resets.
    for (int c = 0; c < 1500; c++) begin
      valid = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
        last[i] = ($urandom_range(3) == 0);
        dat[i]  = 8'($urandom);
      end
      ordy = ($urandom_range(3) != 0);
      if ($urandom_range(199) == 0) do_async_reset();
      else step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
